// File: rtl/stack_seq.sv
// stack_seq: PUSH/POP/CALL/RET sequencer driving an external register file and byte-wide memory.
// Defining STACK_SEQ_TIMEOUT_EN adds a mem_ack timeout that aborts to IDLE with an err pulse.
module stack_seq #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [1:0]  rp,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [4:0]  rf_rd_sel,
   output logic [4:0]  rf_wr_sel,
   output logic [1:0]  rf_ext,
   output logic        rf_we,
   output logic [15:0] rf_wdata,
   input  logic [15:0] rf_rdata,
   output logic        mem_req,
   output logic        mem_we,
   output logic [15:0] mem_addr,
   output logic [7:0]  mem_wdata,
   input  logic [7:0]  mem_rdata,
   input  logic        mem_ack
);

   typedef enum logic [3:0] {
      S_IDLE, S_FETCH, S_DEC_SP, S_WR_HI, S_DEC_SP2, S_WR_LO, S_LOAD, S_WRITE,
      S_RD_SP, S_RD_LO, S_INC_SP, S_RD_HI, S_INC_SP2, S_DONE
   } state_t;

   localparam logic [1:0] OP_PUSH = 2'b00;
   localparam logic [1:0] OP_CALL = 2'b10;
   localparam logic [1:0] OP_RET  = 2'b11;
   localparam logic [1:0] EXT_INC = 2'b01;
   localparam logic [1:0] EXT_DEC = 2'b10;
   localparam logic [4:0] SEL_PC  = 5'b11000;
   localparam logic [4:0] SEL_SP  = 5'b11010;
   localparam logic [4:0] SEL_WZ  = 5'b10110;

   if (TIMEOUT_CYCLES < 1) begin : g_param_check
      $error("stack_seq: TIMEOUT_CYCLES must be at least 1");
   end

   state_t      state_q, state_d;
   logic [1:0]  op_q, op_d;
   logic [1:0]  rp_q, rp_d;
   logic [15:0] a_q, a_d;
   logic [15:0] d_q, d_d;
   logic [4:0]  pair_sel, src_sel, dst_sel;
   logic        is_mem;

   assign pair_sel = {2'b10, rp_q, 1'b0};
   assign src_sel  = (op_q == OP_CALL) ? SEL_PC : pair_sel;
   assign dst_sel  = (op_q == OP_CALL || op_q == OP_RET) ? SEL_PC : pair_sel;
   assign is_mem   = (state_q == S_WR_HI) || (state_q == S_WR_LO) ||
                     (state_q == S_RD_LO) || (state_q == S_RD_HI);
   assign busy     = (state_q != S_IDLE);

`ifdef STACK_SEQ_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;
   logic             timeout;

   // cnt_q counts stalled cycles already spent in the current memory state
   assign timeout = is_mem && !mem_ack && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
   assign err     = err_q;

   always_comb begin
      err_d = timeout;
      cnt_d = cnt_q;
      if (state_d != state_q) cnt_d = '0;
      else if (is_mem)        cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end
`else
   assign err = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      rp_d      = rp_q;
      a_d       = a_q;
      d_d       = d_q;
      done      = 1'b0;
      rf_rd_sel = 5'd0;
      rf_wr_sel = 5'd0;
      rf_ext    = 2'b00;
      rf_we     = 1'b0;
      rf_wdata  = 16'd0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = 16'd0;
      mem_wdata = 8'd0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               op_d    = op;
               rp_d    = rp;
               state_d = (op == OP_PUSH || op == OP_CALL) ? S_FETCH : S_RD_SP;
            end
         end
         S_FETCH: begin
            rf_rd_sel = src_sel;
            d_d       = rf_rdata;
            state_d   = S_DEC_SP;
         end
         S_DEC_SP: begin
            rf_rd_sel = SEL_SP;
            rf_wr_sel = SEL_SP;
            rf_ext    = EXT_DEC;
            a_d       = rf_rdata - 16'd1;
            state_d   = S_WR_HI;
         end
         S_WR_HI: begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = a_q;
            mem_wdata = d_q[15:8];
            if (mem_ack) state_d = S_DEC_SP2;
         end
         S_DEC_SP2: begin
            rf_wr_sel = SEL_SP;
            rf_ext    = EXT_DEC;
            a_d       = a_q - 16'd1;
            state_d   = S_WR_LO;
         end
         S_WR_LO: begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = a_q;
            mem_wdata = d_q[7:0];
            if (mem_ack) state_d = (op_q == OP_CALL) ? S_LOAD : S_DONE;
         end
         S_LOAD: begin
            rf_rd_sel = SEL_WZ;
            d_d       = rf_rdata;
            state_d   = S_WRITE;
         end
         S_WRITE: begin
            rf_we     = 1'b1;
            rf_wr_sel = dst_sel;
            rf_wdata  = d_q;
            state_d   = S_DONE;
         end
         S_RD_SP: begin
            rf_rd_sel = SEL_SP;
            a_d       = rf_rdata;
            state_d   = S_RD_LO;
         end
         S_RD_LO: begin
            mem_req  = 1'b1;
            mem_addr = a_q;
            if (mem_ack) begin
               d_d[7:0] = mem_rdata;
               state_d  = S_INC_SP;
            end
         end
         S_INC_SP: begin
            rf_wr_sel = SEL_SP;
            rf_ext    = EXT_INC;
            a_d       = a_q + 16'd1;
            state_d   = S_RD_HI;
         end
         S_RD_HI: begin
            mem_req  = 1'b1;
            mem_addr = a_q;
            if (mem_ack) begin
               d_d[15:8] = mem_rdata;
               state_d   = S_INC_SP2;
            end
         end
         S_INC_SP2: begin
            rf_wr_sel = SEL_SP;
            rf_ext    = EXT_INC;
            state_d   = S_WRITE;
         end
         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
`ifdef STACK_SEQ_TIMEOUT_EN
      // abandon the operation; SP steps already issued are intentionally kept
      if (timeout) state_d = S_IDLE;
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         op_q    <= 2'b00;
         rp_q    <= 2'b00;
         a_q     <= 16'd0;
         d_q     <= 16'd0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         rp_q    <= rp_d;
         a_q     <= a_d;
         d_q     <= d_d;
      end
   end

endmodule

// File: tb/tb_stack_seq.sv
// Self-checking bench for stack_seq: register-file/memory environment plus a stack-level reference model.
// Also covers the STACK_SEQ_TIMEOUT_EN build when that macro is defined.
module tb_stack_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [1:0]  op, rp;
   logic        busy, done, err;
   logic [4:0]  rf_rd_sel, rf_wr_sel;
   logic [1:0]  rf_ext;
   logic        rf_we;
   logic [15:0] rf_wdata, rf_rdata;
   logic        mem_req, mem_we;
   logic [15:0] mem_addr;
   logic [7:0]  mem_wdata, mem_rdata;
   logic        mem_ack;

   localparam int SP = 26;
   localparam int PC = 24;
   localparam int WZ = 22;

   int checks = 0;
   int errors = 0;
   bit any_err = 1'b0;
   bit any_overlap = 1'b0;

   always #5 clk = ~clk;

   stack_seq #(.TIMEOUT_CYCLES(16)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .rp(rp),
      .busy(busy), .done(done), .err(err),
      .rf_rd_sel(rf_rd_sel), .rf_wr_sel(rf_wr_sel), .rf_ext(rf_ext), .rf_we(rf_we),
      .rf_wdata(rf_wdata), .rf_rdata(rf_rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
   );

   // environment: register file and memory, each with a preload port for the bench
   logic [15:0] regs [0:31];
   logic [7:0]  mem  [0:65535];
   logic        pl_reg_en, pl_mem_en;
   logic [4:0]  pl_reg_idx;
   logic [15:0] pl_reg_val, pl_mem_addr;
   logic [7:0]  pl_mem_val;

   assign rf_rdata  = regs[rf_rd_sel];
   assign mem_rdata = mem[mem_addr];

   always @(posedge clk) begin
      if (pl_reg_en)            regs[pl_reg_idx] <= pl_reg_val;
      else if (rf_we)           regs[rf_wr_sel] <= rf_wdata;
      else if (rf_ext == 2'b01) regs[rf_wr_sel] <= regs[rf_wr_sel] + 16'd1;
      else if (rf_ext == 2'b10) regs[rf_wr_sel] <= regs[rf_wr_sel] - 16'd1;
      if (pl_mem_en)                         mem[pl_mem_addr] <= pl_mem_val;
      else if (mem_req && mem_we && mem_ack) mem[mem_addr] <= mem_wdata;
   end

   task automatic set_reg(input int idx, input logic [15:0] v);
      pl_reg_idx = 5'(idx); pl_reg_val = v; pl_reg_en = 1'b1;
      @(posedge clk); #1;
      pl_reg_en = 1'b0;
   endtask

   task automatic set_mem(input logic [15:0] a, input logic [7:0] v);
      pl_mem_addr = a; pl_mem_val = v; pl_mem_en = 1'b1;
      @(posedge clk); #1;
      pl_mem_en = 1'b0;
   endtask

   // reference model: stack semantics on the whole operation
   logic [15:0] exp_regs [0:31];
   logic [15:0] exp_addr [2];
   logic [7:0]  exp_byte [2];
   int          n_exp;

   task automatic predict(input logic [1:0] o, input logic [1:0] r);
      int          pair;
      logic [15:0] sp, v;
      pair = 16 + 2 * int'(r);
      sp   = regs[SP];
      for (int i = 0; i < 32; i++) exp_regs[i] = regs[i];
      n_exp = 0;
      if (o == 2'b00 || o == 2'b10) begin
         v = (o == 2'b10) ? regs[PC] : regs[pair];
         exp_addr[0] = sp - 16'd1; exp_byte[0] = v[15:8];
         exp_addr[1] = sp - 16'd2; exp_byte[1] = v[7:0];
         n_exp = 2;
         exp_regs[SP] = sp - 16'd2;
         if (o == 2'b10) exp_regs[PC] = regs[WZ];
      end else begin
         v = {mem[sp + 16'd1], mem[sp]};
         exp_regs[SP] = sp + 16'd2;
         if (o == 2'b11) exp_regs[PC] = v;
         else            exp_regs[pair] = v;
      end
   endtask

   task automatic compare_model(input string name);
      int sel [6] = '{16, 18, 20, 22, 24, 26};
      for (int i = 0; i < 6; i++) begin
         checks++;
         if (regs[sel[i]] !== exp_regs[sel[i]]) begin
            errors++;
            $display("FAIL %s reg[%0d] got %h expected %h", name, sel[i], regs[sel[i]], exp_regs[sel[i]]);
         end
      end
      for (int k = 0; k < n_exp; k++) begin
         checks++;
         if (mem[exp_addr[k]] !== exp_byte[k]) begin
            errors++;
            $display("FAIL %s mem[%h] got %h expected %h", name, exp_addr[k], mem[exp_addr[k]], exp_byte[k]);
         end
      end
   endtask

   // mode 0: ack tied high, 1: ack low in cycles 3..5 plus a start pulse in cycle 4, 2: random ack, 3: no ack
   function automatic logic ack_for(input int mode, input int n);
      case (mode)
         0:       return 1'b1;
         1:       return !(n >= 3 && n <= 5);
         2:       return 1'($urandom_range(0, 1));
         default: return 1'b0;
      endcase
   endfunction

   task automatic run_op(input logic [1:0] o, input logic [1:0] r, input int mode,
                         output int lat, output int ecyc);
      logic        pwait, pwe;
      logic [15:0] paddr;
      logic [7:0]  pwd;
      int          n;
      start = 1'b1; op = o; rp = r; mem_ack = ack_for(mode, 0);
      lat = -1; ecyc = -1; n = 0;
      pwait = 1'b0; pwe = 1'b0; paddr = 16'd0; pwd = 8'd0;
      while (lat < 0 && ecyc < 0 && n < 200) begin
         @(posedge clk); #1;
         n++;
         start = (mode == 1 && n == 4);
         op = 2'($urandom); rp = 2'($urandom);
         if (pwait) begin
            checks++;
            if ({mem_req, mem_we, mem_addr, mem_wdata} !== {1'b1, pwe, paddr, pwd}) begin
               errors++;
               $display("FAIL mem_hold cycle %0d got req/we/addr/wdata %b/%b/%h/%h expected 1/%b/%h/%h",
                        n, mem_req, mem_we, mem_addr, mem_wdata, pwe, paddr, pwd);
            end
         end
         if (rf_we && rf_ext != 2'b00) any_overlap = 1'b1;
         if (done) lat = n;
         if (err) begin ecyc = n; any_err = 1'b1; end
         mem_ack = ack_for(mode, n);
         pwait = mem_req && !mem_ack;
         paddr = mem_addr; pwe = mem_we; pwd = mem_wdata;
      end
      start = 1'b0; mem_ack = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL idle_after_op got busy %b done %b expected 0 0", busy, done);
      end
   endtask

   task automatic check_lat(input string name, input int got, input int want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s latency got %0d expected %0d", name, got, want);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; op = 2'b00; rp = 2'b00; mem_ack = 1'b0;
      pl_reg_en = 1'b0; pl_mem_en = 1'b0; pl_reg_idx = 5'd0; pl_reg_val = 16'd0;
      pl_mem_addr = 16'd0; pl_mem_val = 8'd0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({busy, done, err, mem_req, mem_we, mem_addr, mem_wdata, rf_we, rf_ext, rf_wdata,
           rf_rd_sel, rf_wr_sel} !== 58'd0) begin
         errors++;
         $display("FAIL reset_outputs got busy %b mem_req %b rf_we %b rf_ext %b addr %h expected all 0",
                  busy, mem_req, rf_we, rf_ext, mem_addr);
      end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_directed();
      int lat, ec;
      set_reg(18, 16'h1234); set_reg(SP, 16'h2000);
      predict(2'b00, 2'b01); run_op(2'b00, 2'b01, 0, lat, ec);
      check_lat("push_de", lat, 6); compare_model("push_de");
      predict(2'b01, 2'b10); run_op(2'b01, 2'b10, 0, lat, ec);
      check_lat("pop_hl", lat, 7); compare_model("pop_hl");
      checks++;
      if (regs[20] !== 16'h1234) begin
         errors++; $display("FAIL pop_hl value got %h expected 1234", regs[20]);
      end
      set_reg(PC, 16'h0105); set_reg(WZ, 16'h3000); set_reg(SP, 16'h0000);
      predict(2'b10, 2'b00); run_op(2'b10, 2'b00, 0, lat, ec);
      check_lat("call", lat, 8); compare_model("call");
      set_reg(PC, 16'h0000); set_reg(SP, 16'hFFFF);
      set_mem(16'hFFFF, 8'h05); set_mem(16'h0000, 8'h01);
      predict(2'b11, 2'b00); run_op(2'b11, 2'b00, 0, lat, ec);
      check_lat("ret", lat, 7); compare_model("ret");
      checks++;
      if (regs[PC] !== 16'h0105 || regs[SP] !== 16'h0001) begin
         errors++; $display("FAIL ret_value got PC %h SP %h expected 0105 0001", regs[PC], regs[SP]);
      end
   endtask

   task automatic test_stall_and_start();
      int lat, ec;
      set_reg(18, 16'hC3A7); set_reg(SP, 16'h8001);
      predict(2'b00, 2'b01); run_op(2'b00, 2'b01, 1, lat, ec);
      check_lat("push_stall", lat, 9); compare_model("push_stall");
   endtask

   task automatic test_reset_mid_op();
      set_reg(16, 16'hA55A); set_reg(SP, 16'h4000); set_mem(16'h3FFE, 8'h77);
      start = 1'b1; op = 2'b00; rp = 2'b00; mem_ack = 1'b1;
      for (int n = 1; n <= 5; n++) begin
         @(posedge clk); #1;
         start = 1'b0;
      end
      checks++;
      if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 16'h3FFE) begin
         errors++; $display("FAIL rst_setup got req %b we %b addr %h expected 1 1 3ffe", mem_req, mem_we, mem_addr);
      end
      rst = 1'b1;
      #1;
      checks++;
      if ({busy, done, mem_req, mem_we, mem_addr, mem_wdata, rf_we, rf_ext} !== 29'd0) begin
         errors++; $display("FAIL rst_async got busy %b mem_req %b addr %h expected 0 0 0000", busy, mem_req, mem_addr);
      end
      @(posedge clk); #1;
      rst = 1'b0; mem_ack = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (regs[SP] !== 16'h3FFE || mem[16'h3FFF] !== 8'hA5 || mem[16'h3FFE] !== 8'h77 || busy !== 1'b0) begin
         errors++;
         $display("FAIL rst_kept got SP %h hi %h lo %h busy %b expected 3ffe a5 77 0",
                  regs[SP], mem[16'h3FFF], mem[16'h3FFE], busy);
      end
   endtask

`ifdef STACK_SEQ_TIMEOUT_EN
   task automatic test_timeout();
      int lat, ec;
      set_reg(16, 16'hBEEF); set_reg(SP, 16'h5000); set_mem(16'h4FFF, 8'h3C);
      run_op(2'b00, 2'b00, 3, lat, ec);
      check_lat("timeout_err_cycle", ec, 19);
      check_lat("timeout_no_done", lat, -1);
      checks++;
      if (regs[SP] !== 16'h4FFF || mem[16'h4FFF] !== 8'h3C || err !== 1'b0) begin
         errors++;
         $display("FAIL timeout_state got SP %h mem %h err %b expected 4fff 3c 0", regs[SP], mem[16'h4FFF], err);
      end
   endtask
`else
   task automatic test_err_tied();
      checks++;
      if (any_err !== 1'b0) begin
         errors++; $display("FAIL err_tied got err pulse expected none");
      end
   endtask
`endif

   task automatic test_random();
      int          lat_tab [4] = '{6, 7, 8, 7};
      int          lat, ec, mode;
      logic [1:0]  o, r;
      logic [15:0] sp;
      logic [15:0] corners [4] = '{16'h0000, 16'h0001, 16'hFFFF, 16'hFFFE};
      for (int it = 0; it < 40; it++) begin
         o = 2'($urandom); r = 2'($urandom);
         mode = ($urandom_range(0, 1) == 1) ? 2 : 0;
         sp = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 3)] : 16'($urandom);
         for (int k = 16; k <= 24; k += 2) set_reg(k, 16'($urandom));
         set_reg(SP, sp);
         set_mem(sp, 8'($urandom)); set_mem(sp + 16'd1, 8'($urandom));
         predict(o, r);
         run_op(o, r, mode, lat, ec);
         if (mode == 0) check_lat("rand_lat", lat, lat_tab[o]);
         else begin
            checks++;
            if (lat < 6) begin
               errors++; $display("FAIL rand_done op %0d got cycle %0d expected >= 6", o, lat);
            end
         end
         compare_model("rand");
      end
      checks++;
      if (any_overlap !== 1'b0) begin
         errors++; $display("FAIL rf_overlap got rf_we with rf_ext expected never");
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_stall_and_start();
      test_reset_mid_op();
`ifdef STACK_SEQ_TIMEOUT_EN
      test_timeout();
`endif
      test_random();
`ifndef STACK_SEQ_TIMEOUT_EN
      test_err_tied();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/stack_seq.md
STACK_SEQ -- requirements
Module: stack_seq

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, giving mem_ack wait limit in cycles; used only when STACK_SEQ_TIMEOUT_EN is defined.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port start  input  1  operation request, sampled only in IDLE.
REQ-005 SHALL have port op  input  2  operation code: 00 PUSH, 01 POP, 10 CALL, 11 RET.
REQ-006 SHALL have port rp  input  2  register pair for PUSH/POP: 00 BC, 01 DE, 10 HL, 11 WZ.
REQ-007 SHALL have port busy  output  1  high while not in IDLE.
REQ-008 SHALL have port done  output  1  one-cycle completion pulse.
REQ-009 SHALL have port err  output  1  one-cycle timeout-abort pulse.
REQ-010 SHALL have ports rf_rd_sel, rf_wr_sel  output  5 each  register-file read and write selects.
REQ-011 SHALL have ports rf_ext  output  2 (01 INC, 10 DEC) and rf_we  output  1  register-file update controls.
REQ-012 SHALL have ports rf_wdata  output  16 and rf_rdata  input  16  register-file write data and combinational read data.
REQ-013 SHALL have ports mem_req, mem_we  output  1; mem_addr  output  16; mem_wdata  output  8; mem_rdata  input  8; mem_ack  input  1.

Function
REQ-014 SHALL use selects: pair rp = {1,0,rp,0}; PC = 11000; SP = 11010; WZ = 10110.
REQ-015 SHALL hold a 16-bit address latch A and a 16-bit data latch D; all memory addressing is modulo 2^16.
REQ-016 SHALL accept start only in IDLE; start while busy SHALL be ignored; op and rp are latched at acceptance.
REQ-017 PUSH SHALL run FETCH (D<=pair), DEC_SP (rf_ext=DEC, rf_wr_sel=SP, A<=SP-1), WR_HI (write D[15:8] at A), DEC_SP2 (rf_ext=DEC, A<=A-1), WR_LO (write D[7:0] at A), DONE.
REQ-018 POP SHALL run RD_SP (A<=SP), RD_LO (D[7:0]<=mem_rdata), INC_SP (rf_ext=INC, A<=A+1), RD_HI (D[15:8]<=mem_rdata), INC_SP2, WRITE (rf_we=1, rf_wr_sel=pair, rf_wdata=D), DONE.
REQ-019 CALL SHALL run the PUSH sequence with source PC, then LOAD (D<=WZ), WRITE to PC, DONE.
REQ-020 RET SHALL run the POP sequence with destination PC.
REQ-021 In memory states, mem_req SHALL stay high with stable mem_addr/mem_we/mem_wdata until mem_ack is sampled high; the state advances on that edge, and read data is captured on that edge.
REQ-022 mem_ack while mem_req is low SHALL be ignored.
REQ-023 rf_we and rf_ext SHALL be nonzero only in the states named above; rf_we and rf_ext SHALL never be active in the same cycle.
REQ-024 done SHALL be high only in DONE, which returns to IDLE next cycle.
REQ-025 With mem_ack tied high, done SHALL assert 6 cycles after the start cycle for PUSH, 7 for POP, 8 for CALL, and 7 for RET.

Reset
REQ-026 rst SHALL force IDLE immediately, also mid-operation; A, D, and all outputs are then 0. Register-file and memory updates already completed SHALL NOT be undone.

Configuration
REQ-027 With STACK_SEQ_TIMEOUT_EN defined, a counter cleared on entering each memory state SHALL abort to IDLE with err high for one cycle after TIMEOUT_CYCLES cycles without mem_ack, and done SHALL stay low; SP decrements/increments already issued remain.
REQ-028 Without STACK_SEQ_TIMEOUT_EN, no counter SHALL exist, waits SHALL be unbounded, and err SHALL be tied 0.

Verification
REQ-029 PUSH DE, DE=1234, SP=2000, ack tied high -> mem[1FFF]=12, mem[1FFE]=34, SP=1FFE, done in cycle 6.
REQ-030 POP HL, SP=1FFE with mem 34,12 -> HL=1234, SP=2000, done in cycle 7.
REQ-031 CALL, PC=0105, WZ=3000, SP=0000 -> mem[FFFF]=01, mem[FFFE]=05, SP=FFFE, PC=3000.
REQ-032 RET, SP=FFFF, mem[FFFF]=05, mem[0000]=01 -> PC=0105, SP=0001.
REQ-033 PUSH with ack delayed 3 cycles in WR_HI; start pulsed mid-op -> addr/wdata stable throughout, second start ignored, done in cycle 9.
REQ-034 rst pulsed during WR_LO of a PUSH -> busy=0 and mem_req=0 immediately; with STACK_SEQ_TIMEOUT_EN defined, ack withheld for 16 cycles -> err pulse, done stays 0.
